// File: rtl/ps2_key_serializer.sv
// Turns hps_io ps2_key toggle events into device-side PS/2 frames (start, 8 data LSB first,
// odd parity, stop) on registered clock/data lines that idle high.
module ps2_key_serializer #(
    parameter int unsigned HALF_PERIOD = 1145,
    parameter int unsigned GAP         = 2290,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    output logic        ps2_clk,
    output logic        ps2_data,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned TMAX = (HALF_PERIOD > GAP) ? HALF_PERIOD : GAP;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] HalfLoad = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] GapLoad  = TW'(GAP - 1);
    localparam logic [CW-1:0] DepthC   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {PIdle, PE0, PF0, PCode} push_st_e;
    typedef enum logic [1:0] {SIdle, SHigh, SLow, SGap} ser_st_e;

    push_st_e push_st_q, push_st_d;
    logic     prev_toggle_q, prev_toggle_d;
    logic     pressed_q, pressed_d;
    logic     ext_q, ext_d;
    logic [7:0] code_q, code_d;
    logic     overflow_q, overflow_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_en, pop_en;
    logic [7:0]    push_byte;
    logic [CW-1:0] free_cnt;
    logic [1:0]    needed;

    ser_st_e       ser_st_q, ser_st_d;
    logic [10:0]   frame_q, frame_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          data_q, data_d;

    assign free_cnt = DepthC - count_q;
    assign needed   = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, ~ps2_key[9]};

    // Acceptance reserves all bytes of an event up front, so a push never finds the FIFO full.
    always_comb begin
        push_st_d     = push_st_q;
        prev_toggle_d = prev_toggle_q;
        pressed_d     = pressed_q;
        ext_d         = ext_q;
        code_d        = code_q;
        overflow_d    = 1'b0;
        push_en       = 1'b0;
        push_byte     = code_q;
        unique case (push_st_q)
            PIdle: begin
                if (ps2_key[10] != prev_toggle_q) begin
                    prev_toggle_d = ps2_key[10];
                    pressed_d     = ps2_key[9];
                    ext_d         = ps2_key[8];
                    code_d        = ps2_key[7:0];
                    if (free_cnt >= CW'(needed)) begin
                        if (ps2_key[8])       push_st_d = PE0;
                        else if (!ps2_key[9]) push_st_d = PF0;
                        else                  push_st_d = PCode;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            PE0: begin
                push_en   = 1'b1;
                push_byte = 8'hE0;
                push_st_d = pressed_q ? PCode : PF0;
            end
            PF0: begin
                push_en   = 1'b1;
                push_byte = 8'hF0;
                push_st_d = PCode;
            end
            PCode: begin
                push_en   = 1'b1;
                push_byte = code_q;
                push_st_d = PIdle;
            end
            default: push_st_d = PIdle;
        endcase
    end

    always_comb begin
        ser_st_d = ser_st_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        pop_en   = 1'b0;
        unique case (ser_st_q)
            SIdle: begin
                if (count_q != '0) begin
                    pop_en   = 1'b1;
                    frame_d  = {1'b1, ~^mem_q[rd_ptr_q], mem_q[rd_ptr_q], 1'b0};
                    idx_d    = 4'd0;
                    cnt_d    = HalfLoad;
                    ser_st_d = SHigh;
                end
            end
            SHigh: begin
                if (cnt_q == '0) begin
                    cnt_d    = HalfLoad;
                    ser_st_d = SLow;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SLow: begin
                if (cnt_q == '0) begin
                    if (idx_q == 4'd10) begin
                        cnt_d    = GapLoad;
                        ser_st_d = SGap;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        cnt_d    = HalfLoad;
                        ser_st_d = SHigh;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SGap: begin
                if (cnt_q == '0) ser_st_d = SIdle;
                else             cnt_d    = cnt_q - 1'b1;
            end
            default: ser_st_d = SIdle;
        endcase
        // Line levels follow the next state so they line up with the state register.
        clk_d  = (ser_st_d != SLow);
        data_d = (ser_st_d == SHigh || ser_st_d == SLow) ? frame_d[idx_d] : 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            push_st_q     <= PIdle;
            prev_toggle_q <= ps2_key[10];
            pressed_q     <= 1'b0;
            ext_q         <= 1'b0;
            code_q        <= 8'h00;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ser_st_q      <= SIdle;
            frame_q       <= '1;
            idx_q         <= 4'd0;
            cnt_q         <= '0;
            clk_q         <= 1'b1;
            data_q        <= 1'b1;
        end else begin
            push_st_q     <= push_st_d;
            prev_toggle_q <= prev_toggle_d;
            pressed_q     <= pressed_d;
            ext_q         <= ext_d;
            code_q        <= code_d;
            overflow_q    <= overflow_d;
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_en && !pop_en)      count_q <= count_q + CW'(1);
            else if (!push_en && pop_en) count_q <= count_q - CW'(1);
            ser_st_q      <= ser_st_d;
            frame_q       <= frame_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            clk_q         <= clk_d;
            data_q        <= data_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_en) mem_q[wr_ptr_q] <= push_byte;
    end

    assign ps2_clk  = clk_q;
    assign ps2_data = data_q;
    assign overflow = overflow_q;
    assign busy     = (ser_st_q != SIdle) | (count_q != '0) | (push_st_q != PIdle);

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Directed bench for ps2_key_serializer: decodes the PS/2 line on falling clock edges and
// compares captured frames, timing and overflow pulses with hand-computed values.
module tb_ps2_key_serializer;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] ps2_key = '0;
    logic        ps2_clk, ps2_data, busy, overflow;
    logic        tog = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          nbit = 0;
    logic [10:0] shreg = '0;
    logic        prev_clk = 1'b1;
    logic [7:0]  bytes_seen[$];
    logic [10:0] frames_seen[$];
    int          fall_t[$];
    int          frame_err = 0;
    int          ovf_cnt = 0;
    int          busy_cycles = 0;
    int          clk_low_seen = 0;

    ps2_key_serializer #(
        .HALF_PERIOD(4),
        .GAP        (8),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_key (ps2_key),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Line monitor: frames are shifted in LSB first so bit 0 holds the start bit.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (reset) begin
                nbit     = 0;
                prev_clk = 1'b1;
            end else begin
                if (prev_clk && !ps2_clk) begin
                    shreg = {ps2_data, shreg[10:1]};
                    fall_t.push_back(cyc);
                    nbit++;
                    if (nbit == 11) begin
                        frames_seen.push_back(shreg);
                        bytes_seen.push_back(shreg[8:1]);
                        if (shreg[0] !== 1'b0 || shreg[10] !== 1'b1 || shreg[9] !== ~^shreg[8:1])
                            frame_err++;
                        nbit = 0;
                    end
                end
                prev_clk = ps2_clk;
                if (overflow) ovf_cnt++;
                if (busy) busy_cycles++;
                if (!ps2_clk) clk_low_seen++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_ev(input logic press, input logic ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, press, ext, code};
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_mon();
        bytes_seen.delete();
        frames_seen.delete();
        fall_t.delete();
        frame_err    = 0;
        ovf_cnt      = 0;
        busy_cycles  = 0;
        clk_low_seen = 0;
    endtask

    initial begin
        logic [7:0] codes[4];
        logic [7:0] exp4[7];
        int n;
        codes = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp4  = '{8'h1C, 8'hE0, 8'hF0, 8'h11, 8'hE0, 8'hF0, 8'h22};

        // Reset and quiet line
        repeat (3) @(negedge clk_sys);
        check_eq("rst clk", 32'(ps2_clk), 32'd1);
        check_eq("rst data", 32'(ps2_data), 32'd1);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        clear_mon();
        repeat (100) @(negedge clk_sys);
        check_eq("quiet clk low", 32'(clk_low_seen), 32'd0);
        check_eq("quiet frames", 32'(frames_seen.size()), 32'd0);
        check_eq("quiet busy", 32'(busy), 32'd0);

        // Single press of 0x1C
        clear_mon();
        send_ev(1'b1, 1'b0, 8'h1C);
        @(negedge clk_sys);
        wait_idle("t2", 300);
        check_eq("t2 frames", 32'(frames_seen.size()), 32'd1);
        check_eq("t2 frame bits", 32'(frames_seen[0]), 32'h438);
        check_eq("t2 busy cycles", 32'(busy_cycles), 32'd98);
        check_eq("t2 bit period", 32'(fall_t[1] - fall_t[0]), 32'd8);

        // Extended release of 0x75
        clear_mon();
        send_ev(1'b0, 1'b1, 8'h75);
        @(negedge clk_sys);
        wait_idle("t3", 1000);
        check_eq("t3 frames", 32'(frames_seen.size()), 32'd3);
        check_eq("t3 byte0", 32'(bytes_seen[0]), 32'hE0);
        check_eq("t3 byte1", 32'(bytes_seen[1]), 32'hF0);
        check_eq("t3 byte2", 32'(bytes_seen[2]), 32'h75);
        check_eq("t3 par0", 32'(frames_seen[0][9]), 32'd0);
        check_eq("t3 par1", 32'(frames_seen[1][9]), 32'd1);
        check_eq("t3 par2", 32'(frames_seen[2][9]), 32'd0);
        check_eq("t3 spacing01", 32'(fall_t[11] - fall_t[10]), 32'd17);
        check_eq("t3 spacing12", 32'(fall_t[22] - fall_t[21]), 32'd17);
        check_eq("t3 frame err", 32'(frame_err), 32'd0);

        // Overflow: 1 byte in flight, then 4 three-byte events; only two fit
        clear_mon();
        send_ev(1'b1, 1'b0, 8'h1C);
        repeat (10) @(negedge clk_sys);
        for (int i = 0; i < 4; i++) begin
            send_ev(1'b0, 1'b1, codes[i]);
            repeat (5) @(negedge clk_sys);
        end
        wait_idle("t4", 3000);
        check_eq("t4 overflow pulses", 32'(ovf_cnt), 32'd2);
        check_eq("t4 byte count", 32'(bytes_seen.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            check_eq($sformatf("t4 byte%0d", i), 32'(bytes_seen[i]), 32'(exp4[i]));
        check_eq("t4 frame err", 32'(frame_err), 32'd0);

        // Reset in the middle of bit 5 with one more byte queued
        clear_mon();
        send_ev(1'b1, 1'b0, 8'h1C);
        repeat (2) @(negedge clk_sys);
        send_ev(1'b1, 1'b0, 8'h2A);
        n = 0;
        while (nbit < 6 && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq("t5 reached bit5", 32'(nbit), 32'd6);
        reset = 1'b1;
        @(negedge clk_sys);
        check_eq("t5 rst clk", 32'(ps2_clk), 32'd1);
        check_eq("t5 rst data", 32'(ps2_data), 32'd1);
        check_eq("t5 rst busy", 32'(busy), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        clear_mon();
        repeat (60) @(negedge clk_sys);
        check_eq("t5 fifo flushed", 32'(frames_seen.size()), 32'd0);
        check_eq("t5 line quiet", 32'(clk_low_seen), 32'd0);
        send_ev(1'b1, 1'b0, 8'h5A);
        @(negedge clk_sys);
        wait_idle("t5b", 300);
        check_eq("t5 frames", 32'(frames_seen.size()), 32'd1);
        check_eq("t5 frame bits", 32'(frames_seen[0]), 32'h6B4);

        // Second event detected on the cycle the serializer pops the only entry
        clear_mon();
        send_ev(1'b1, 1'b0, 8'h1C);
        @(negedge clk_sys);
        send_ev(1'b1, 1'b1, 8'h6B);
        @(negedge clk_sys);
        wait_idle("t6", 2000);
        check_eq("t6 byte count", 32'(bytes_seen.size()), 32'd3);
        check_eq("t6 byte0", 32'(bytes_seen[0]), 32'h1C);
        check_eq("t6 byte1", 32'(bytes_seen[1]), 32'hE0);
        check_eq("t6 byte2", 32'(bytes_seen[2]), 32'h6B);
        check_eq("t6 overflow", 32'(ovf_cnt), 32'd0);
        check_eq("t6 frame err", 32'(frame_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion",
                 n_checks);
        $fatal(1);
    end

endmodule
